ad1939_dac_stream_rx: RTL



---
 rtl/ad1939_dac_stream_rx.sv | 174 +++++++++++++++++
 1 files changed

// File: rtl/ad1939_dac_stream_rx.sv
// AD1939 DAC-side I2S receiver: oversampled deserializer onto a ready/valid stream.
// Define AD1939_DAC_RX_ERR_EN to build frame-length, overflow and status_clr logic.
module ad1939_dac_stream_rx #(
  parameter int DATA_WIDTH  = 24,
  parameter int SLOT_WIDTH  = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset_n,
  input  logic                  dbclk,
  input  logic                  dlrclk,
  input  logic                  dsdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_channel,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  frame_err,
  output logic                  overflow,
  input  logic                  status_clr
);

  localparam int IW = $clog2(SLOT_WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    SKIP,
    SHIFT,
    PAD
  } state_t;

  logic [SYNC_STAGES-1:0] bck_s;
  logic [SYNC_STAGES-1:0] lrc_s;
  logic [SYNC_STAGES-1:0] dat_s;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bck_s <= '0;
      lrc_s <= '0;
      dat_s <= '0;
    end else begin
      bck_s <= {bck_s[SYNC_STAGES-2:0], dbclk};
      lrc_s <= {lrc_s[SYNC_STAGES-2:0], dlrclk};
      dat_s <= {dat_s[SYNC_STAGES-2:0], dsdata};
    end
  end

  // Registered edge detect; LR and data ride along so they stay aligned.
  logic bck_p;
  logic strb;
  logic lr_smp;
  logic d_smp;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      bck_p  <= 1'b0;
      strb   <= 1'b0;
      lr_smp <= 1'b0;
      d_smp  <= 1'b0;
    end else begin
      bck_p  <= bck_s[SYNC_STAGES-1];
      strb   <= bck_s[SYNC_STAGES-1] & ~bck_p;
      lr_smp <= lrc_s[SYNC_STAGES-1];
      d_smp  <= dat_s[SYNC_STAGES-1];
    end
  end

  state_t                state;
  state_t                state_n;
  logic                  lr_q;
  logic [IW-1:0]         idx;
  logic [IW-1:0]         idx_n;
  logic [DATA_WIDTH-2:0] shreg;
  logic [DATA_WIDTH-1:0] word;
  logic                  lr_edge;
  logic                  shift_en;
  logic                  complete;

  assign lr_edge = strb & (lr_smp ^ lr_q);
  assign word    = {shreg, d_smp};

  always_comb begin
    idx_n = idx;
    if (lr_edge)
      idx_n = '0;
    else if (idx != IW'(SLOT_WIDTH))
      idx_n = idx + IW'(1);
  end

  always_comb begin
    state_n  = state;
    shift_en = 1'b0;
    complete = 1'b0;
    if (strb) begin
      unique case (state)
        IDLE: if (lr_edge) state_n = SKIP;
        SKIP: begin
          if (!lr_edge) begin
            state_n  = SHIFT;
            shift_en = 1'b1;
          end
        end
        SHIFT: begin
          if (lr_edge) begin
            state_n = SKIP;
          end else begin
            shift_en = 1'b1;
            if (idx_n == IW'(DATA_WIDTH)) begin
              complete = 1'b1;
              state_n  = PAD;
            end
          end
        end
        PAD: if (lr_edge) state_n = SKIP;
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state <= IDLE;
      lr_q  <= 1'b0;
      idx   <= '0;
      shreg <= '0;
    end else begin
      state <= state_n;
      if (strb) begin
        lr_q <= lr_smp;
        idx  <= idx_n;
        if (shift_en)
          shreg <= word[DATA_WIDTH-2:0];
      end
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      out_data    <= '0;
      out_channel <= 1'b0;
      out_valid   <= 1'b0;
    end else if (complete && (!out_valid || out_ready)) begin
      out_data    <= word;
      out_channel <= lr_q;
      out_valid   <= 1'b1;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

`ifdef AD1939_DAC_RX_ERR_EN
  logic slot_bad;
  logic drop;

  // idx at an LR edge is the previous slot's strobe count minus one.
  assign slot_bad = lr_edge && (state != IDLE) &&
                    (idx != IW'(SLOT_WIDTH - 1));
  assign drop     = complete && out_valid && !out_ready;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      frame_err <= slot_bad | (frame_err & ~status_clr);
      overflow  <= drop | (overflow & ~status_clr);
    end
  end
`else
  logic unused_clr;
  assign unused_clr = status_clr;
  assign frame_err  = 1'b0;
  assign overflow   = 1'b0;
`endif

endmodule
